// File: rtl/param_mode_counter_pkg.sv
// Shared types and defaults for the parameterised mode counter.
//   mode_e     : counting mode selected on the mode port
//   state_e    : ONESHOT sequencer states
//   WIDTH_DEF  : default count width
//   STEP_W_DEF : default step width
package param_mode_counter_pkg;

  localparam int unsigned WIDTH_DEF  = 4;
  localparam int unsigned STEP_W_DEF = 2;

  typedef enum logic [1:0] {
    ModeWrap    = 2'd0,
    ModeSat     = 2'd1,
    ModeModulo  = 2'd2,
    ModeOneshot = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/param_mode_counter_cnt_next_calc.sv
// Next-count arithmetic for param_mode_counter (purely combinational).
//   count      : current count
//   step       : unsigned increment
//   up_down    : 1 = up, 0 = down
//   mode       : counting mode
//   lo_bound   : lower range bound (MODULO / ONESHOT)
//   hi_bound   : upper range bound (MODULO / ONESHOT)
//   next_count : candidate next count
//   clip       : carry / borrow / clamp / bound-reached event this step
//   clip_up    : 1 when the event is on the upper side (overflow)
module cnt_next_calc
  import param_mode_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              up_down,
  input  mode_e             mode,
  input  logic [WIDTH-1:0]  lo_bound,
  input  logic [WIDTH-1:0]  hi_bound,
  output logic [WIDTH-1:0]  next_count,
  output logic              clip,
  output logic              clip_up
);

  // One extra bit holds carry on the way up and borrow on the way down.
  logic [WIDTH:0] cnt_x, step_x, lo_x, hi_x, sum, diff, lo_plus;

  assign cnt_x   = {1'b0, count};
  assign step_x  = (WIDTH + 1)'(step);
  assign lo_x    = {1'b0, lo_bound};
  assign hi_x    = {1'b0, hi_bound};
  assign sum     = cnt_x + step_x;
  assign diff    = cnt_x - step_x;
  assign lo_plus = lo_x + step_x;

  always_comb begin
    next_count = count;
    clip       = 1'b0;
    clip_up    = up_down;
    if (step != '0) begin
      unique case (mode)
        ModeWrap: begin
          next_count = up_down ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
          clip       = up_down ? sum[WIDTH] : diff[WIDTH];
        end
        ModeSat: begin
          if (up_down) begin
            next_count = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
            clip       = sum[WIDTH];
          end else begin
            next_count = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
            clip       = diff[WIDTH];
          end
        end
        ModeModulo: begin
          if (up_down) begin
            clip       = (sum > hi_x);
            next_count = clip ? lo_bound : sum[WIDTH-1:0];
          end else begin
            clip       = (cnt_x < lo_plus);
            next_count = clip ? hi_bound : diff[WIDTH-1:0];
          end
        end
        ModeOneshot: begin
          // Reaching or passing the bound lands exactly on it.
          if (up_down) begin
            clip       = (sum >= hi_x);
            next_count = clip ? hi_bound : sum[WIDTH-1:0];
          end else begin
            clip       = (cnt_x <= lo_plus);
            next_count = clip ? lo_bound : diff[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/param_mode_counter.sv
// Multi-mode up/down counter with WRAP, SAT, MODULO and ONESHOT modes.
//   clk, rst_n           : clock, synchronous active-low reset
//   load_n, data_load    : active-low parallel load and its value
//   ce, up_down, step    : count enable, direction, increment
//   mode                 : counting mode
//   lo_bound, hi_bound   : range for MODULO / ONESHOT
//   start                : ONESHOT arm pulse
//   clr_flags            : clears ovf / unf
//   count_out            : registered count
//   zero, max_count      : count == 0 / all-ones
//   at_lo, at_hi         : count == lo_bound / hi_bound
//   tc                   : registered one-cycle terminal/clip pulse
//   ovf, unf             : sticky overflow / underflow
//   busy                 : ONESHOT run in progress
//   cfg_err              : bounds inverted in a ranged mode
module param_mode_counter
  import param_mode_counter_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_n,
  input  logic              ce,
  input  logic              up_down,
  input  mode_e             mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  data_load,
  input  logic [WIDTH-1:0]  lo_bound,
  input  logic [WIDTH-1:0]  hi_bound,
  input  logic              start,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count_out,
  output logic              zero,
  output logic              max_count,
  output logic              at_lo,
  output logic              at_hi,
  output logic              tc,
  output logic              ovf,
  output logic              unf,
  output logic              busy,
  output logic              cfg_err
);

  logic [WIDTH-1:0] count_q, next_count;
  logic             tc_q, ovf_q, unf_q;
  logic             clip, clip_up;
  logic             oneshot;
  state_e           state_q;

  assign oneshot = (mode == ModeOneshot);
  assign cfg_err = ((mode == ModeModulo) || oneshot) && (lo_bound > hi_bound);

  cnt_next_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .count      (count_q),
    .step       (step),
    .up_down    (up_down),
    .mode       (mode),
    .lo_bound   (lo_bound),
    .hi_bound   (hi_bound),
    .next_count (next_count),
    .clip       (clip),
    .clip_up    (clip_up)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      state_q <= StIdle;
    end else begin
      tc_q <= 1'b0;
      // Clear first; a set later in this block overrides it.
      if (clr_flags) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      if (!load_n) begin
        count_q <= data_load;
      end else if (start && oneshot && (state_q != StRun) && !cfg_err) begin
        count_q <= up_down ? lo_bound : hi_bound;
        state_q <= StRun;
      end else if (ce && !cfg_err) begin
        if (oneshot) begin
          // Only a running sequence advances; IDLE and DONE hold.
          if (state_q == StRun) begin
            count_q <= next_count;
            if (clip) begin
              tc_q    <= 1'b1;
              state_q <= StDone;
            end
          end
        end else begin
          count_q <= next_count;
          if (clip) begin
            tc_q <= 1'b1;
            if (clip_up) ovf_q <= 1'b1;
            else         unf_q <= 1'b1;
          end
        end
      end
      if (!oneshot) state_q <= StIdle;
    end
  end

  assign count_out = count_q;
  assign tc        = tc_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign busy      = (state_q == StRun);
  assign zero      = (count_q == '0);
  assign max_count = &count_q;
  assign at_lo     = (count_q == lo_bound);
  assign at_hi     = (count_q == hi_bound);

endmodule

// File: tb/tb_param_mode_counter.sv
// Directed table-driven bench for param_mode_counter at WIDTH=4, STEP_W=2.
module tb_param_mode_counter;
  import param_mode_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, load_n, ce, up_down, start, clr_flags;
  mode_e      mode;
  logic [1:0] step;
  logic [3:0] data_load, lo_bound, hi_bound;
  logic [3:0] count_out;
  logic       zero, max_count, at_lo, at_hi, tc, ovf, unf, busy, cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  param_mode_counter #(
    .WIDTH  (4),
    .STEP_W (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_n    (load_n),
    .ce        (ce),
    .up_down   (up_down),
    .mode      (mode),
    .step      (step),
    .data_load (data_load),
    .lo_bound  (lo_bound),
    .hi_bound  (hi_bound),
    .start     (start),
    .clr_flags (clr_flags),
    .count_out (count_out),
    .zero      (zero),
    .max_count (max_count),
    .at_lo     (at_lo),
    .at_hi     (at_hi),
    .tc        (tc),
    .ovf       (ovf),
    .unf       (unf),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst_n, load_n, ce, up, start, clr;
    mode_e      mode;
    logic [1:0] step;
    logic [3:0] dl, lo, hi;
    logic [3:0] e_cnt;
    logic       e_tc, e_ovf, e_unf, e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, bit r, bit ld, bit c, bit u, mode_e m, int stp, int dl,
                              int lo, int hi, bit st, bit cl, int ec, bit etc, bit eo, bit eu,
                              bit eb);
    vec_t v;
    v.name = n;   v.rst_n = r;  v.load_n = ld; v.ce = c; v.up = u; v.start = st; v.clr = cl;
    v.mode = m;   v.step = 2'(stp); v.dl = 4'(dl); v.lo = 4'(lo); v.hi = 4'(hi);
    v.e_cnt = 4'(ec); v.e_tc = etc; v.e_ovf = eo; v.e_unf = eu; v.e_busy = eb;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst_n = v.rst_n; load_n = v.load_n; ce = v.ce; up_down = v.up; start = v.start;
    clr_flags = v.clr; mode = v.mode; step = v.step; data_load = v.dl;
    lo_bound = v.lo; hi_bound = v.hi;
  endtask

  task automatic check_vec(vec_t v);
    logic e_cfg;
    e_cfg = ((v.mode == ModeModulo) || (v.mode == ModeOneshot)) && (v.lo > v.hi);
    chk({v.name, ".count"}, 8'(count_out), 8'(v.e_cnt));
    chk({v.name, ".tc"}, 8'(tc), 8'(v.e_tc));
    chk({v.name, ".ovf"}, 8'(ovf), 8'(v.e_ovf));
    chk({v.name, ".unf"}, 8'(unf), 8'(v.e_unf));
    chk({v.name, ".busy"}, 8'(busy), 8'(v.e_busy));
    chk({v.name, ".zero"}, 8'(zero), 8'(v.e_cnt == 4'd0));
    chk({v.name, ".max"}, 8'(max_count), 8'(v.e_cnt == 4'd15));
    chk({v.name, ".at_lo"}, 8'(at_lo), 8'(v.e_cnt == v.lo));
    chk({v.name, ".at_hi"}, 8'(at_hi), 8'(v.e_cnt == v.hi));
    chk({v.name, ".cfg_err"}, 8'(cfg_err), 8'(e_cfg));
  endtask

  initial begin
    int   cycles;
    bit   seen_tc;
    vec_t v;

    //   name        rst ld ce up mode         st dl lo hi st cl  cnt tc ov un by
    add("reset",      0, 1, 1, 1, ModeWrap,    1, 5, 0,15, 1, 0,   0, 0, 0, 0, 0);
    add("w_load14",   1, 0, 1, 1, ModeWrap,    3,14, 0,15, 0, 0,  14, 0, 0, 0, 0);
    add("w_carry",    1, 1, 1, 1, ModeWrap,    3, 0, 0,15, 0, 0,   1, 1, 1, 0, 0);
    add("w_clr",      1, 1, 1, 1, ModeWrap,    3, 0, 0,15, 0, 1,   4, 0, 0, 0, 0);
    add("w_dn",       1, 1, 1, 0, ModeWrap,    3, 0, 0,15, 0, 0,   1, 0, 0, 0, 0);
    add("w_borrow",   1, 1, 1, 0, ModeWrap,    3, 0, 0,15, 0, 0,  14, 1, 0, 1, 0);
    add("w_step0",    1, 1, 1, 0, ModeWrap,    0, 0, 0,15, 0, 0,  14, 0, 0, 1, 0);
    add("w_setwins",  1, 1, 1, 1, ModeWrap,    3, 0, 0,15, 0, 1,   1, 1, 1, 0, 0);
    add("w_clr2",     1, 1, 0, 1, ModeWrap,    3, 0, 0,15, 0, 1,   1, 0, 0, 0, 0);
    add("s_load1",    1, 0, 1, 0, ModeSat,     2, 1, 0,15, 0, 0,   1, 0, 0, 0, 0);
    add("s_clamp0",   1, 1, 1, 0, ModeSat,     2, 0, 0,15, 0, 0,   0, 1, 0, 1, 0);
    add("s_hold0",    1, 1, 1, 0, ModeSat,     2, 0, 0,15, 0, 0,   0, 1, 0, 1, 0);
    add("s_load14",   1, 0, 1, 1, ModeSat,     2,14, 0,15, 0, 0,  14, 0, 0, 1, 0);
    add("s_clamp15",  1, 1, 1, 1, ModeSat,     2, 0, 0,15, 0, 0,  15, 1, 1, 1, 0);
    add("s_hold15",   1, 1, 1, 1, ModeSat,     1, 0, 0,15, 0, 0,  15, 1, 1, 1, 0);
    add("s_clr",      1, 1, 0, 1, ModeSat,     1, 0, 0,15, 0, 1,  15, 0, 0, 0, 0);
    add("m_load8",    1, 0, 1, 1, ModeModulo,  2, 8, 3, 9, 0, 0,   8, 0, 0, 0, 0);
    add("m_upwrap",   1, 1, 1, 1, ModeModulo,  2, 0, 3, 9, 0, 0,   3, 1, 1, 0, 0);
    add("m_up",       1, 1, 1, 1, ModeModulo,  2, 0, 3, 9, 0, 0,   5, 0, 1, 0, 0);
    add("m_load4",    1, 0, 1, 0, ModeModulo,  2, 4, 3, 9, 0, 0,   4, 0, 1, 0, 0);
    add("m_dnwrap",   1, 1, 1, 0, ModeModulo,  2, 0, 3, 9, 0, 0,   9, 1, 1, 1, 0);
    add("m_dn",       1, 1, 1, 0, ModeModulo,  2, 0, 3, 9, 0, 0,   7, 0, 1, 1, 0);
    add("m_cfgerr",   1, 1, 1, 1, ModeModulo,  2, 0, 9, 3, 0, 0,   7, 0, 1, 1, 0);
    add("m_cfgload",  1, 0, 1, 1, ModeModulo,  2, 2, 9, 3, 0, 0,   2, 0, 1, 1, 0);
    add("m_clr",      1, 1, 0, 1, ModeModulo,  2, 0, 3, 9, 0, 1,   2, 0, 0, 0, 0);
    add("o_start",    1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 1, 0,   2, 0, 0, 0, 1);
    add("o_s4",       1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 0, 0,   4, 0, 0, 0, 1);
    add("o_s6",       1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 0, 0,   6, 0, 0, 0, 1);
    add("o_s7",       1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 0, 0,   7, 1, 0, 0, 0);
    add("o_done",     1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 0, 0,   7, 0, 0, 0, 0);
    add("o_ldprio",   1, 0, 1, 1, ModeOneshot, 2,11, 2, 7, 1, 0,  11, 0, 0, 0, 0);
    add("o_start2",   1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 1, 0,   2, 0, 0, 0, 1);
    add("o_stinrun",  1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 1, 0,   4, 0, 0, 0, 1);
    add("o_ldinrun",  1, 0, 1, 1, ModeOneshot, 2, 5, 2, 7, 0, 0,   5, 0, 0, 0, 1);
    add("o_reach",    1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 0, 0,   7, 1, 0, 0, 0);
    add("o_dnstart",  1, 1, 1, 0, ModeOneshot, 2, 0, 2, 7, 1, 0,   7, 0, 0, 0, 1);
    add("o_d5",       1, 1, 1, 0, ModeOneshot, 2, 0, 2, 7, 0, 0,   5, 0, 0, 0, 1);
    add("o_d3",       1, 1, 1, 0, ModeOneshot, 2, 0, 2, 7, 0, 0,   3, 0, 0, 0, 1);
    add("o_d2",       1, 1, 1, 0, ModeOneshot, 2, 0, 2, 7, 0, 0,   2, 1, 0, 0, 0);
    add("a_start",    1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 1, 0,   2, 0, 0, 0, 1);
    add("a_s4",       1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 0, 0,   4, 0, 0, 0, 1);
    add("a_reset",    0, 0, 1, 1, ModeOneshot, 2, 9, 2, 7, 1, 0,   0, 0, 0, 0, 0);
    add("a_idle",     1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 0, 0,   0, 0, 0, 0, 0);
    add("x_start",    1, 1, 1, 1, ModeOneshot, 2, 0, 2, 7, 1, 0,   2, 0, 0, 0, 1);
    add("x_modeexit", 1, 1, 0, 1, ModeWrap,    2, 0, 2, 7, 0, 0,   2, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_vec(vecs[i]);
    end

    // Longer ONESHOT run with overshoot: 0,3,6,9,12 then clipped to 13.
    @(negedge clk);
    v = vecs[0];
    v.rst_n = 1; v.load_n = 1; v.ce = 1; v.up = 1; v.start = 1; v.clr = 0;
    v.mode = ModeOneshot; v.step = 2'd3; v.lo = 4'd0; v.hi = 4'd13;
    drive(v);
    @(posedge clk);
    #1;
    chk("os_arm.count", 8'(count_out), 8'd0);
    chk("os_arm.busy", 8'(busy), 8'd1);
    start   = 1'b0;
    cycles  = 0;
    seen_tc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (tc) begin
        seen_tc = 1'b1;
        break;
      end
    end
    chk("os_tc_seen", 8'(seen_tc), 8'd1);
    chk("os_cycles", 8'(cycles), 8'd5);
    chk("os_final.count", 8'(count_out), 8'd13);
    chk("os_final.busy", 8'(busy), 8'd0);
    chk("os_final.ovf", 8'(ovf), 8'd0);
    @(posedge clk);
    #1;
    chk("os_hold.count", 8'(count_out), 8'd13);
    chk("os_hold.tc", 8'(tc), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_mode_counter.md
PARAM_MODE_COUNTER -- requirements
Module: param_mode_counter

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 4: count width in bits.
REQ-002 The block SHALL expose parameter STEP_W, default 2: width of the step increment.
REQ-003 Port clk  input  1: rising-edge clock.
REQ-004 Port rst_n  input  1: reset, synchronous, active-low.
REQ-005 Port load_n  input  1: active-low parallel load.
REQ-006 Port ce  input  1: count enable.
REQ-007 Port up_down  input  1: 1 = count up, 0 = count down.
REQ-008 Port mode  input  2: mode_e, one of WRAP, SAT, MODULO, ONESHOT.
REQ-009 Port step  input  STEP_W: unsigned increment per enabled cycle.
REQ-010 Port data_load  input  WIDTH: load value.
REQ-011 Port lo_bound, hi_bound  input  WIDTH each: range for MODULO and ONESHOT.
REQ-012 Port start  input  1: one-cycle arm pulse for ONESHOT.
REQ-013 Port clr_flags  input  1: clears the sticky flags.
REQ-014 Port count_out  output  WIDTH: registered count.
REQ-015 Ports zero, max_count, at_lo, at_hi  output  1 each: combinational compares of count_out against 0, all-ones, lo_bound and hi_bound.
REQ-016 Port tc  output  1: registered one-cycle terminal/clip pulse.
REQ-017 Ports ovf, unf  output  1 each: sticky overflow and underflow flags.
REQ-018 Port busy  output  1: high while the ONESHOT FSM is in RUN.
REQ-019 Port cfg_err  output  1: combinational, high when mode is MODULO or ONESHOT and lo_bound > hi_bound.

Function
REQ-020 Per-edge priority SHALL be: rst_n, then load_n, then start, then ce; the lower-priority actions are ignored that cycle.
REQ-021 Load SHALL set count_out = data_load verbatim in every mode, with no tc and no flag change.
REQ-022 Arithmetic SHALL be computed in WIDTH+1 bits to detect carry and borrow.
REQ-023 With step = 0 and ce = 1, count SHALL hold with no tc and no flag change.
REQ-024 WRAP mode: count SHALL be count +/- step mod 2^WIDTH; on carry, tc = 1 and ovf is set; on borrow, tc = 1 and unf is set.
REQ-025 SAT mode: the result SHALL clamp to all-ones (up) or 0 (down); each clamping cycle, including a hold at the limit, SHALL give tc = 1 and set ovf or unf.
REQ-026 MODULO mode, up: if count + step > hi_bound, next count SHALL be lo_bound, with tc = 1 and ovf set.
REQ-027 MODULO mode, down: if count < lo_bound + step, next count SHALL be hi_bound, with tc = 1 and unf set.
REQ-028 ONESHOT FSM SHALL have states IDLE, RUN, DONE, with reset state IDLE.
REQ-029 ONESHOT: start in IDLE or DONE SHALL load count = lo_bound (up) or hi_bound (down) and enter RUN; start in RUN is ignored.
REQ-030 ONESHOT RUN with ce: count SHALL step toward hi_bound (up) or lo_bound (down); on reaching or passing the bound, count = bound, tc = 1, and the FSM enters DONE; no ovf or unf.
REQ-031 ONESHOT DONE: count SHALL hold until the next start or load.
REQ-032 A load during RUN SHALL update count and the FSM SHALL stay in RUN.
REQ-033 When mode is not ONESHOT, the FSM SHALL return to IDLE on the next edge.
REQ-034 busy SHALL be 1 only in RUN.
REQ-035 While cfg_err = 1, count SHALL hold, except that load still applies.
REQ-036 clr_flags SHALL clear ovf and unf; a set event in the same cycle wins over the clear.
REQ-037 tc SHALL be 0 in every cycle without an event.

Reset
REQ-038 rst_n = 0 at a clock edge SHALL set count_out = 0, tc = 0, ovf = 0, unf = 0, FSM = IDLE, regardless of load_n, ce or start.
REQ-039 Reset during ONESHOT RUN SHALL abort the run: busy = 0 and no tc.
REQ-040 After reset, outputs SHALL be zero = 1, max_count = 0, and busy = 0.

Structure
REQ-041 The shared package SHALL hold mode_e, the FSM state enum, and the WIDTH_DEF and STEP_W_DEF constants.
REQ-042 The next-value arithmetic SHALL be one sub-module, cnt_next_calc, taking count, step, direction, mode and bounds and returning next count, clip/carry, and direction of overflow; the registers and FSM stay in the top module.

Verification (WIDTH = 4, STEP_W = 2)
REQ-043 Reset test: ce = 1, up, rst_n = 0 for one edge -> count 0, zero 1, tc/ovf/unf 0, busy 0.
REQ-044 WRAP test: load 14, step 3, up -> count 1, tc pulse, ovf 1; then clr_flags -> ovf 0, count 4.
REQ-045 SAT test: load 1, step 2, down -> count 0, unf 1, tc; next cycle count 0 and tc 1 again.
REQ-046 MODULO test: lo 3, hi 9. Up from 8, step 2 -> 3, tc, ovf. Down from 4, step 2 -> 9, unf.
REQ-047 ONESHOT test: lo 2, hi 7, step 2, up, start -> 2, 4, 6, 7 with tc on 7, then DONE, busy 0, count holds 7.
REQ-048 Priority and abort test: load_n = 0 with ce = 1 and start -> count = data_load; rst_n = 0 mid-RUN -> IDLE and count 0; lo 9 with hi 3 in MODULO -> cfg_err 1 and count holds.
